multicycle_control: RTL and testbench

//  Moore-FSM control unit for the RV32I multicycle datapath (single shared memory, IR/OldPC latches).

---
 rtl/multicycle_control_pkg.sv | 66 ++++++
 rtl/alu_decoder.sv | 30 +++
 rtl/multicycle_control.sv | 161 ++++++++++++++++
 tb/tb_multicycle_control.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the RV32I multicycle control unit:
// opcodes, FSM states, ALU/ImmSrc codes and the per-state control bundle.
package multicycle_control_pkg;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMREAD  = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWRITE = 4'd5;
   localparam logic [3:0] S_EXECUTER = 4'd6;
   localparam logic [3:0] S_EXECUTEI = 4'd7;
   localparam logic [3:0] S_JAL      = 4'd8;
   localparam logic [3:0] S_ALUWB    = 4'd9;
   localparam logic [3:0] S_BEQ      = 4'd10;
   localparam logic [3:0] S_TRAP     = 4'd11;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   typedef struct packed {
      logic       pcupdate;
      logic       branch;
      logic       adrsrc;
      logic       memwrite;
      logic       irwrite;
      logic       regwrite;
      logic [1:0] resultsrc;
      logic [1:0] alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic       done;
      logic       illegal;
   } ctrl_t;

   function automatic logic [1:0] imm_sel(input logic [6:0] op);
      logic [1:0] s;
      case (op)
         OP_SW:   s = IMM_S;
         OP_BEQ:  s = IMM_B;
         OP_JAL:  s = IMM_J;
         default: s = IMM_I;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: ALUOp plus funct fields to ALUControl.
// Subtraction for funct3=000 only on R-type (op5) with funct7b5.
module alu_decoder
   import multicycle_control_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       op5,
   output logic [2:0] alucontrol
);

   always_comb begin
      alucontrol = ALU_ADD;
      case (aluop)
         ALUOP_SUB: alucontrol = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  alucontrol = ALU_SLT;
               3'b110:  alucontrol = ALU_OR;
               3'b111:  alucontrol = ALU_AND;
               default: alucontrol = ALU_ADD;
            endcase
         end
         default: alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the RV32I multicycle datapath.
// Define MC_ILLEGAL_TRAP_EN to park unsupported opcodes in an absorbing TRAP.
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int STATE_W = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUControl,
   output logic [1:0] ImmSrc,
   output logic       instr_done,
   output logic       illegal
);

   logic [STATE_W-1:0] state;
   logic [STATE_W-1:0] next;
   ctrl_t              c;

   logic is_mem, is_lw, is_r, is_i, is_jal, is_beq, legal;

   assign is_lw  = (op == OP_LW);
   assign is_mem = is_lw | (op == OP_SW);
   assign is_r   = (op == OP_R);
   assign is_i   = (op == OP_I);
   assign is_jal = (op == OP_JAL);
   assign is_beq = (op == OP_BEQ);
   assign legal  = is_mem | is_r | is_i | is_jal | is_beq;

   always_ff @(posedge clk) begin
      if (reset) state <= S_FETCH;
      else       state <= next;
   end

   always_comb begin
      next = S_FETCH;
      case (state)
         S_FETCH: next = S_DECODE;
         S_DECODE: begin
            unique case (1'b1)
               is_mem:  next = S_MEMADR;
               is_r:    next = S_EXECUTER;
               is_i:    next = S_EXECUTEI;
               is_jal:  next = S_JAL;
               is_beq:  next = S_BEQ;
`ifdef MC_ILLEGAL_TRAP_EN
               default: next = S_TRAP;
`else
               default: next = S_FETCH;
`endif
            endcase
         end
         S_MEMADR:   next = is_lw ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  next = S_MEMWB;
         S_EXECUTER: next = S_ALUWB;
         S_EXECUTEI: next = S_ALUWB;
         S_JAL:      next = S_ALUWB;
`ifdef MC_ILLEGAL_TRAP_EN
         S_TRAP:     next = S_TRAP;
`endif
         default:    next = S_FETCH;
      endcase
   end

   always_comb begin
      c = '0;
      case (state)
         S_FETCH: begin
            c.irwrite   = 1'b1;
            c.pcupdate  = 1'b1;
            c.alusrcb   = 2'b10;
            c.resultsrc = 2'b10;
         end
         S_DECODE: begin
            c.alusrca = 2'b01;
            c.alusrcb = 2'b01;
`ifndef MC_ILLEGAL_TRAP_EN
            // Unsupported op retires here as a NOP
            c.done    = ~legal;
`endif
         end
         S_MEMADR: begin
            c.alusrca = 2'b10;
            c.alusrcb = 2'b01;
         end
         S_MEMREAD: c.adrsrc = 1'b1;
         S_MEMWB: begin
            c.resultsrc = 2'b01;
            c.regwrite  = 1'b1;
            c.done      = 1'b1;
         end
         S_MEMWRITE: begin
            c.adrsrc   = 1'b1;
            c.memwrite = 1'b1;
            c.done     = 1'b1;
         end
         S_EXECUTER: begin
            c.alusrca = 2'b10;
            c.aluop   = ALUOP_FUNCT;
         end
         S_EXECUTEI: begin
            c.alusrca = 2'b10;
            c.alusrcb = 2'b01;
            c.aluop   = ALUOP_FUNCT;
         end
         S_JAL: begin
            c.alusrca  = 2'b01;
            c.alusrcb  = 2'b10;
            c.pcupdate = 1'b1;
         end
         S_ALUWB: begin
            c.regwrite = 1'b1;
            c.done     = 1'b1;
         end
         S_BEQ: begin
            c.alusrca = 2'b10;
            c.aluop   = ALUOP_SUB;
            c.branch  = 1'b1;
            c.done    = 1'b1;
         end
`ifdef MC_ILLEGAL_TRAP_EN
         S_TRAP: c.illegal = 1'b1;
`endif
         default: c = '0;
      endcase
   end

   alu_decoder u_alu_decoder (
      .aluop      (c.aluop),
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .op5        (op[5]),
      .alucontrol (ALUControl)
   );

   // Enables are masked so a reset cycle never commits a write
   assign PCWrite    = ~reset & (c.pcupdate | (c.branch & zero));
   assign MemWrite   = ~reset & c.memwrite;
   assign IRWrite    = ~reset & c.irwrite;
   assign RegWrite   = ~reset & c.regwrite;
   assign instr_done = ~reset & c.done;
   assign AdrSrc     = c.adrsrc;
   assign ResultSrc  = c.resultsrc;
   assign ALUSrcA    = c.alusrca;
   assign ALUSrcB    = c.alusrcb;
   assign ImmSrc     = imm_sel(op);
   assign illegal    = c.illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: table vectors, corner sequences, random
// instruction streams against a per-instruction cycle-script model.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] op = 7'd0;
   logic [2:0] funct3 = 3'd0;
   logic       funct7b5 = 1'b0;
   logic       zero = 1'b0;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;
   logic       instr_done, illegal;

   multicycle_control dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3),
      .funct7b5(funct7b5), .zero(zero), .PCWrite(PCWrite),
      .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
      .instr_done(instr_done), .illegal(illegal)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int prev_done = 0;

   // -1 in a field means the spec leaves it don't-care in that cycle
   typedef struct {
      int pcw, irw, mw, rw, done, ill;
      int adr, rs, sa, sb, alu;
   } exp_t;

   typedef struct {
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7;
      logic       z;
      int         ncyc;
      int         imm;
      int         acyc;
      int         alu;
   } vec_t;

   exp_t q[$];

   task automatic chk(input string nm, input int act, input int exp);
      if (exp < 0) return;
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input int pcw, irw, mw, rw, done, ill,
                               input int adr, rs, sa, sb, alu);
      exp_t e;
      e.pcw = pcw; e.irw = irw; e.mw = mw; e.rw = rw;
      e.done = done; e.ill = ill; e.adr = adr; e.rs = rs;
      e.sa = sa; e.sb = sb; e.alu = alu;
      return e;
   endfunction

   function automatic bit is_legal(input logic [6:0] o);
      return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
             o == 7'b0010011 || o == 7'b1101111 || o == 7'b1100011;
   endfunction

   function automatic int imm_of(input logic [6:0] o);
      case (o)
         7'b0100011: return 1;
         7'b1100011: return 2;
         7'b1101111: return 3;
         default:    return 0;
      endcase
   endfunction

   function automatic int exec_alu(input logic [6:0] o, input logic [2:0] f3,
                                   input logic f7);
      logic [6:0] ov;
      ov = o;
      case (f3)
         3'd0:    return (ov[5] && f7) ? 1 : 0;
         3'd2:    return 5;
         3'd6:    return 3;
         3'd7:    return 2;
         default: return 0;
      endcase
   endfunction

   // Cycle script of one instruction, straight from the state table
   task automatic build(input logic [6:0] o, input logic [2:0] f3,
                        input logic f7, input logic z);
      exp_t wb;
      q.delete();
      q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 2, 0, 2, 0));
      wb = mk(0, 0, 0, 1, 1, 0, -1, 0, -1, -1, -1);
      if (!is_legal(o)) begin
`ifdef MC_ILLEGAL_TRAP_EN
         q.push_back(mk(0, 0, 0, 0, 0, 0, -1, -1, 1, 1, 0));
         repeat (4) q.push_back(mk(0, 0, 0, 0, 0, 1, -1, -1, -1, -1, -1));
`else
         q.push_back(mk(0, 0, 0, 0, 1, 0, -1, -1, 1, 1, 0));
`endif
         return;
      end
      q.push_back(mk(0, 0, 0, 0, 0, 0, -1, -1, 1, 1, 0));
      case (o)
         7'b0000011: begin
            q.push_back(mk(0, 0, 0, 0, 0, 0, -1, -1, 2, 1, 0));
            q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, -1, -1, -1));
            q.push_back(mk(0, 0, 0, 1, 1, 0, -1, 1, -1, -1, -1));
         end
         7'b0100011: begin
            q.push_back(mk(0, 0, 0, 0, 0, 0, -1, -1, 2, 1, 0));
            q.push_back(mk(0, 0, 1, 0, 1, 0, 1, 0, -1, -1, -1));
         end
         7'b0110011: begin
            q.push_back(mk(0, 0, 0, 0, 0, 0, -1, -1, 2, 0, exec_alu(o, f3, f7)));
            q.push_back(wb);
         end
         7'b0010011: begin
            q.push_back(mk(0, 0, 0, 0, 0, 0, -1, -1, 2, 1, exec_alu(o, f3, f7)));
            q.push_back(wb);
         end
         7'b1101111: begin
            q.push_back(mk(1, 0, 0, 0, 0, 0, -1, 0, 1, 2, 0));
            q.push_back(wb);
         end
         default: begin
            q.push_back(mk(int'(z), 0, 0, 0, 1, 0, -1, 0, 2, 0, 1));
         end
      endcase
   endtask

   // Entered and left at a negedge; compares #1 after each negedge
   task automatic run(input logic [6:0] o, input logic [2:0] f3,
                      input logic f7, input logic z, input int maxc,
                      output int ncyc, output int alu_obs[12]);
      exp_t e;
      int   i;
      op = o; funct3 = f3; funct7b5 = f7; zero = z;
      build(o, f3, f7, z);
      ncyc = 0;
      i = 0;
      for (int k = 0; k < 12; k++) alu_obs[k] = -1;
      while (q.size() > 0 && i < maxc) begin
         e = q.pop_front();
         i++;
         #1;
         alu_obs[i] = int'(ALUControl);
         chk("PCWrite", int'(PCWrite), e.pcw);
         chk("IRWrite", int'(IRWrite), e.irw);
         chk("MemWrite", int'(MemWrite), e.mw);
         chk("RegWrite", int'(RegWrite), e.rw);
         chk("instr_done", int'(instr_done), e.done);
         chk("illegal", int'(illegal), e.ill);
         chk("AdrSrc", int'(AdrSrc), e.adr);
         chk("ResultSrc", int'(ResultSrc), e.rs);
         chk("ALUSrcA", int'(ALUSrcA), e.sa);
         chk("ALUSrcB", int'(ALUSrcB), e.sb);
         chk("ALUControl", int'(ALUControl), e.alu);
         chk("ImmSrc", int'(ImmSrc), imm_of(o));
         if (instr_done) begin
            chk("done_back_to_back", prev_done, 0);
            if (ncyc == 0) ncyc = i;
         end
         prev_done = int'(instr_done);
         @(negedge clk);
      end
   endtask

   task automatic chk_quiet(input string nm);
      #1;
      chk({nm, "_PCWrite"}, int'(PCWrite), 0);
      chk({nm, "_IRWrite"}, int'(IRWrite), 0);
      chk({nm, "_MemWrite"}, int'(MemWrite), 0);
      chk({nm, "_RegWrite"}, int'(RegWrite), 0);
      chk({nm, "_done"}, int'(instr_done), 0);
   endtask

   vec_t vt[11];
   int   nc;
   int   obs[12];

   initial begin
      vt[0]  = '{7'b0000011, 3'd2, 1'b0, 1'b0, 5, 0, 3, 0};
      vt[1]  = '{7'b0100011, 3'd2, 1'b0, 1'b0, 4, 1, 3, 0};
      vt[2]  = '{7'b0110011, 3'd0, 1'b1, 1'b0, 4, 0, 3, 1};
      vt[3]  = '{7'b0110011, 3'd0, 1'b0, 1'b0, 4, 0, 3, 0};
      vt[4]  = '{7'b0110011, 3'd2, 1'b0, 1'b1, 4, 0, 3, 5};
      vt[5]  = '{7'b0110011, 3'd6, 1'b0, 1'b0, 4, 0, 3, 3};
      vt[6]  = '{7'b0110011, 3'd7, 1'b1, 1'b0, 4, 0, 3, 2};
      vt[7]  = '{7'b0010011, 3'd0, 1'b1, 1'b0, 4, 0, 3, 0};
      vt[8]  = '{7'b1100011, 3'd0, 1'b0, 1'b1, 3, 2, 3, 1};
      vt[9]  = '{7'b1100011, 3'd0, 1'b0, 1'b0, 3, 2, 3, 1};
      vt[10] = '{7'b1101111, 3'd0, 1'b0, 1'b0, 4, 3, 3, 0};

      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk_quiet("reset");
      @(negedge clk);
      reset = 1'b0;

      for (int v = 0; v < 11; v++) begin
         run(vt[v].op, vt[v].f3, vt[v].f7, vt[v].z, 20, nc, obs);
         chk($sformatf("vec%0d_cycles", v), nc, vt[v].ncyc);
         chk($sformatf("vec%0d_alu", v), obs[vt[v].acyc], vt[v].alu);
         chk($sformatf("vec%0d_imm", v), int'(ImmSrc), vt[v].imm);
      end

      // Reset held two cycles while a lw sits in MEMREAD
      run(7'b0000011, 3'd2, 1'b0, 1'b0, 3, nc, obs);
      reset = 1'b1;
      chk_quiet("rst_memread");
      @(negedge clk);
      chk_quiet("rst_fetch");
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("post_reset_IRWrite", int'(IRWrite), 1);
      chk("post_reset_PCWrite", int'(PCWrite), 1);
      @(negedge clk);
      prev_done = 0;
      // Step back into FETCH: DECODE of lw (op still lw) now needs flushing
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;

      run(7'b1111111, 3'd0, 1'b0, 1'b0, 20, nc, obs);
`ifdef MC_ILLEGAL_TRAP_EN
      chk("trap_no_done", nc, 0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
`else
      chk("nop_cycles", nc, 2);
`endif
      prev_done = 0;
      run(7'b0000011, 3'd0, 1'b0, 1'b0, 20, nc, obs);
      chk("recover_lw_cycles", nc, 5);

      for (int r = 0; r < 150; r++) begin
         logic [6:0] ro;
         int k;
         k = $urandom_range(0, 6);
         case (k)
            0: ro = 7'b0000011;
            1: ro = 7'b0100011;
            2: ro = 7'b0110011;
            3: ro = 7'b0010011;
            4: ro = 7'b1101111;
            5: ro = 7'b1100011;
`ifdef MC_ILLEGAL_TRAP_EN
            default: ro = 7'b0110011;
`else
            default: ro = ($urandom_range(0, 1) == 0) ? 7'b0110111 : 7'b1110011;
`endif
         endcase
         run(ro, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 20, nc, obs);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
